// File: rtl/sseg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment table, blank
// pattern and the width helper used to size the scan counters.
package sseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entries are in a..g reading order (leftmost bit = segment a, 0 = lit);
    // seg_pins() turns one into pin order where bit 0 drives segment a.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [6:0] seg_pins(input logic [6:0] abcdefg);
        logic [6:0] pins;
        pins = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            pins[i] = abcdefg[6 - i];
        end
        return pins;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Display data and pin bundle between a host and the seven-segment scan driver.
interface sseg_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                    en;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp;
    logic [N_DIGITS-1:0]     blank;
    logic                    load;
    logic [6:0]              sseg;
    logic                    dp_n;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_done;

    modport master (
        output en, value, dp, blank, load,
        input  sseg, dp_n, an, frame_done
    );

    modport slave (
        input  en, value, dp, blank, load,
        output sseg, dp_n, an, frame_done
    );
endinterface

// File: rtl/sseg_scan_driver_hex_rom.sv
// Combinational hex nibble to active-low segment lookup, pin order (bit 0 = a).
module sseg_hex_rom
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pins(SEG_TABLE[nibble]);
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-synchronous
// loading, leading-zero blanking and an anode-off guard at the start of each slot.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned TICK_DIV  = 12500,
    parameter int unsigned GUARD_CYC = 16,
    parameter int unsigned LZ_BLANK  = 1
) (
    input  logic               clk,
    input  logic               rst,
    sseg_scan_driver_if.slave  bus
);

    localparam int unsigned IDX_W = width_of(N_DIGITS);
    localparam int unsigned PRE_W = width_of(TICK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD    = PRE_W'(GUARD_CYC);

    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;

    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;
    logic [4*N_DIGITS-1:0] pend_value;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic                  pend_valid;

    logic [6:0]            sseg_q;
    logic                  dp_n_q;
    logic [N_DIGITS-1:0]   an_q;
    logic                  frame_done_q;

    logic                  slot_end;
    logic                  wrap;
    logic [N_DIGITS-1:0]   lz;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [6:0]            rom_seg;
    logic [N_DIGITS-1:0]   an_next;

    always_comb begin
        slot_end = (presc == PRE_LAST);
        wrap     = slot_end && (idx == IDX_LAST);
    end

    // Leading zeros are found by walking from the top digit down; digit 0 never blanks.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            zero_run = zero_run && (shadow_value[4*(N_DIGITS-1-j) +: 4] == 4'h0);
            lz[N_DIGITS-1-j] = (LZ_BLANK != 0) && zero_run && (j != N_DIGITS - 1);
        end
    end

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                cur_nib  = shadow_value[4*k +: 4];
                cur_dp   = shadow_dp[k];
                cur_dark = shadow_blank[k] | lz[k];
            end
        end
    end

    always_comb begin
        an_next = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if ((IDX_W'(k) == idx) && bus.en && !cur_dark && (presc >= GUARD)) begin
                an_next[k] = 1'b0;
            end
        end
    end

    sseg_hex_rom u_rom (
        .nibble (cur_nib),
        .seg    (rom_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= wrap ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load landing on the wrap edge bypasses pending so it shows in the frame starting now.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_valid   <= 1'b0;
        end else if (wrap) begin
            if (bus.load) begin
                shadow_value <= bus.value;
                shadow_dp    <= bus.dp;
                shadow_blank <= bus.blank;
            end else if (pend_valid) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
                shadow_blank <= pend_blank;
            end
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp;
            pend_blank <= bus.blank;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sseg_q       <= SEG_OFF;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            sseg_q       <= cur_dark ? SEG_OFF : rom_seg;
            dp_n_q       <= ~cur_dp;
            an_q         <= an_next;
            frame_done_q <= wrap;
        end
    end

    assign bus.sseg       = sseg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: table of display words plus scan-timing,
// load-ordering, enable and reset sequences.
module tb_sseg_scan_driver;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [3:0]       blank;
        logic             en;
        logic [3:0][6:0]  seg;
        logic [3:0]       lit;
        logic [3:0]       dpn;
    } vec_t;

    localparam int NV_TABLE = 7;
    localparam logic [6:0] OFF = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Spec table in a..g reading order; converted to pin order (bit 0 = a) below.
    logic [6:0] abcdefg [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [6:0] seg_of [16];
    vec_t       vecs [10];

    always #5 clk = ~clk;

    sseg_scan_driver_if #(.N_DIGITS(4)) bus ();

    sseg_scan_driver #(
        .N_DIGITS  (4),
        .TICK_DIV  (8),
        .GUARD_CYC (2),
        .LZ_BLANK  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.value = v;
        bus.dp    = d;
        bus.blank = b;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (bus.frame_done === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s frame_done timeout: got none expected pulse within 80 cycles", tag);
    endtask

    // Entered in the frame_done cycle; samples each slot at prescaler 1 (guard) and 2 (first lit).
    task automatic check_frame(input vec_t v, input string tag);
        logic [3:0] exp_an;
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 2 : 7);
            chk($sformatf("%s d%0d guard an", tag, d), 16'(bus.an), 16'hF);
            step(1);
            exp_an = v.lit[d] ? ~(4'b0001 << d) : 4'b1111;
            chk($sformatf("%s d%0d an", tag, d), 16'(bus.an), 16'(exp_an));
            chk($sformatf("%s d%0d sseg", tag, d), 16'(bus.sseg), 16'(v.seg[d]));
            chk($sformatf("%s d%0d dp_n", tag, d), 16'(bus.dp_n), 16'(v.dpn[d]));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bus.en = v.en;
        do_load(v.value, v.dp, v.blank);
        wait_frame(tag);
        check_frame(v, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        int         low [4];
        int         fd_pos;
        int         fd_cnt;
        int         dark_bad;

        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 7; b++) seg_of[i][b] = abcdefg[i][6 - b];
        end

        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b1,
                    {seg_of[1], seg_of[2], seg_of[10], seg_of[15]}, 4'b1111, 4'b1111};
        vecs[1] = '{16'h0030, 4'b0000, 4'b0000, 1'b1,
                    {OFF, OFF, seg_of[3], seg_of[0]}, 4'b0011, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                    {OFF, OFF, OFF, seg_of[0]}, 4'b0001, 4'b1111};
        vecs[3] = '{16'h8421, 4'b0111, 4'b0010, 1'b1,
                    {seg_of[8], seg_of[4], OFF, seg_of[1]}, 4'b1101, 4'b1000};
        vecs[4] = '{16'h0A07, 4'b0000, 4'b0000, 1'b1,
                    {OFF, seg_of[10], seg_of[0], seg_of[7]}, 4'b0111, 4'b1111};
        vecs[5] = '{16'hEDCB, 4'b1000, 4'b0000, 1'b1,
                    {seg_of[14], seg_of[13], seg_of[12], seg_of[11]}, 4'b1111, 4'b0111};
        vecs[6] = '{16'h5555, 4'b0000, 4'b0000, 1'b0,
                    {seg_of[5], seg_of[5], seg_of[5], seg_of[5]}, 4'b0000, 4'b1111};
        vecs[7] = '{16'h5555, 4'b0000, 4'b0000, 1'b1,
                    {seg_of[5], seg_of[5], seg_of[5], seg_of[5]}, 4'b1111, 4'b1111};
        vecs[8] = '{16'h1111, 4'b0000, 4'b0000, 1'b1,
                    {seg_of[1], seg_of[1], seg_of[1], seg_of[1]}, 4'b1111, 4'b1111};
        vecs[9] = '{16'h2222, 4'b0000, 4'b0000, 1'b1,
                    {seg_of[2], seg_of[2], seg_of[2], seg_of[2]}, 4'b1111, 4'b1111};

        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.value = '0;
        bus.dp    = '0;
        bus.blank = '0;
        bus.load  = 1'b0;
        step(3);
        chk("reset an", 16'(bus.an), 16'hF);
        chk("reset sseg", 16'(bus.sseg), 16'(OFF));
        chk("reset dp_n", 16'(bus.dp_n), 16'h1);
        chk("reset frame_done", 16'(bus.frame_done), 16'h0);
        rst = 1'b0;

        // First wrap after release lands 32 cycles later.
        fd_pos = 0;
        for (int i = 1; i <= 40 && fd_pos == 0; i++) begin
            @(negedge clk);
            if (bus.frame_done) fd_pos = i;
        end
        chk("first frame_done cycle", 16'(fd_pos), 16'd32);

        // Duty and frame_done spacing over one full 12AF frame.
        do_load(16'h12AF, 4'b0000, 4'b0000);
        wait_frame("duty");
        low = '{0, 0, 0, 0};
        fd_cnt = 0;
        fd_pos = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (bus.an[d] == 1'b0) low[d]++;
            if (bus.frame_done) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
        chk("low cycles per digit", {4'(low[3]), 4'(low[2]), 4'(low[1]), 4'(low[0])}, 16'h6666);
        chk("frame_done once per frame", 16'(fd_cnt), 16'd1);
        chk("frame_done spacing", 16'(fd_pos), 16'd32);

        for (int i = 0; i < NV_TABLE; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        bus.en = 1'b1;

        // Two loads inside one frame: current frame stays on 1111, next shows the last load.
        do_load(16'h1111, 4'b0000, 4'b0000);
        wait_frame("lastwins");
        step(10);
        do_load(16'h9999, 4'b0000, 4'b0000);
        step(4);
        do_load(16'h2222, 4'b0000, 4'b0000);
        step(3);
        chk("lastwins d2 an", 16'(bus.an), 16'hB);
        chk("lastwins d2 old sseg", 16'(bus.sseg), 16'(seg_of[1]));
        step(8);
        chk("lastwins d3 an", 16'(bus.an), 16'h7);
        chk("lastwins d3 old sseg", 16'(bus.sseg), 16'(seg_of[1]));
        wait_frame("lastwins next");
        check_frame(vecs[9], "lastwins next");

        // Load held exactly on the wrap edge goes straight into the frame that begins there.
        step(4);
        bus.value = 16'h5555;
        bus.dp    = 4'b0000;
        bus.blank = 4'b0000;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("wrapload frame_done", 16'(bus.frame_done), 16'h1);
        check_frame(vecs[7], "wrapload");

        // en low for 40 cycles: dark anodes, frame timing unchanged.
        wait_frame("enable");
        bus.en = 1'b0;
        dark_bad = 0;
        fd_cnt = 0;
        fd_pos = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.an !== 4'hF) dark_bad++;
            if (bus.frame_done) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
        chk("en0 anodes lit count", 16'(dark_bad), 16'd0);
        chk("en0 frame_done count", 16'(fd_cnt), 16'd1);
        chk("en0 frame_done spacing", 16'(fd_pos), 16'd32);
        bus.en = 1'b1;
        step(4);
        chk("en1 resume an", 16'(bus.an), 16'hD);
        chk("en1 resume sseg", 16'(bus.sseg), 16'(seg_of[5]));

        // Reset in the middle of slot 2 with a load pending.
        do_load(16'h8888, 4'b0000, 4'b0000);
        step(7);
        chk("prereset an", 16'(bus.an), 16'hB);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset an", 16'(bus.an), 16'hF);
        chk("midreset sseg", 16'(bus.sseg), 16'(OFF));
        chk("midreset dp_n", 16'(bus.dp_n), 16'h1);
        chk("midreset frame_done", 16'(bus.frame_done), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        fd_pos = 0;
        for (int i = 1; i <= 40 && fd_pos == 0; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("postreset idx0 an", 16'(bus.an), 16'hE);
                chk("postreset idx0 sseg", 16'(bus.sseg), 16'(seg_of[0]));
            end
            if (bus.frame_done) fd_pos = i;
        end
        chk("postreset frame_done cycle", 16'(fd_pos), 16'd32);
        check_frame(vecs[2], "postreset blank shadow");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
